shift_unit_arbiter: RTL and testbench

//  Shares one combinational barrel shifter (SLL/SRL/SRA) between two requesters
//  (req0 = ALU shift path, req1 = address/immediate formatting path) using

---
 rtl/shift_pkg.sv | 19 +
 rtl/shift_core.sv | 35 +++
 rtl/shift_unit_arbiter.sv | 108 ++++++++++
 tb/tb_shift_unit_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shared shift unit: op encodings, width defaults
// and the response-slot state type.
package shift_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_SHAMT_W = 5;

  localparam logic [1:0] SHIFT_OP_SLL = 2'b00;
  localparam logic [1:0] SHIFT_OP_SRL = 2'b01;
  localparam logic [1:0] SHIFT_OP_SRA = 2'b10;
  localparam logic [1:0] SHIFT_OP_RSV = 2'b11;

  // Output slot is either empty or holding one response
  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_t;

endpackage

// File: rtl/shift_core.sv
// Purely combinational barrel shifter: logical left, logical right and
// arithmetic right units followed by an op mux. The reserved op passes the
// operand through untouched.
module shift_core
  import shift_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  output logic [DATA_W-1:0]  out,
  input  logic [DATA_W-1:0]  in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         op
);

  logic [DATA_W-1:0] sll_res;
  logic [DATA_W-1:0] srl_res;
  logic [DATA_W-1:0] sra_res;

  assign sll_res = in << shamt;
  assign srl_res = in >> shamt;
  assign sra_res = $unsigned($signed(in) >>> shamt);

  // Pick the unit result that matches the requested op
  always_comb begin
    out = in;
    case (op)
      SHIFT_OP_SLL: out = sll_res;
      SHIFT_OP_SRL: out = srl_res;
      SHIFT_OP_SRA: out = sra_res;
      default:      out = in;
    endcase
  end

endmodule

// File: rtl/shift_unit_arbiter.sv
// Round-robin arbiter sharing one shift_core between two requesters, with a
// single registered response slot (1-cycle latency, 1 op/cycle when the
// consumer is always ready) and a wrapping completed-response counter.
module shift_unit_arbiter
  import shift_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SHAMT_W = DEF_SHAMT_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_data,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic [1:0]         req0_op,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_data,
  input  logic [SHAMT_W-1:0] req1_shamt,
  input  logic [1:0]         req1_op,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_err,
  output logic [CNT_W-1:0]   op_count
);

  rsp_state_t         state_q;
  rsp_state_t         state_d;
  logic               prio;
  logic               can_accept;
  logic               grant0;
  logic               grant1;
  logic               accept;
  logic [DATA_W-1:0]  mux_data;
  logic [SHAMT_W-1:0] mux_shamt;
  logic [1:0]         mux_op;
  logic [DATA_W-1:0]  shift_res;

  assign rsp_valid  = (state_q == RSP_FULL);
  assign can_accept = !rsp_valid || rsp_ready;

  // A lone requester always wins; on a tie the prio holder wins
  assign grant0 = req0_valid && (!req1_valid || !prio);
  assign grant1 = req1_valid && (!req0_valid || prio);

  assign req0_ready = can_accept && grant0;
  assign req1_ready = can_accept && grant1;
  assign accept     = can_accept && (grant0 || grant1);

  assign mux_data  = grant1 ? req1_data  : req0_data;
  assign mux_shamt = grant1 ? req1_shamt : req0_shamt;
  assign mux_op    = grant1 ? req1_op    : req0_op;

  shift_core #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_core (
    .out   (shift_res),
    .in    (mux_data),
    .shamt (mux_shamt),
    .op    (mux_op)
  );

  // Response slot state register; reset drops any pending response at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RSP_EMPTY;
    else        state_q <= state_d;
  end

  // Slot fills on accept, empties when drained with nothing new arriving
  always_comb begin
    state_d = state_q;
    case (state_q)
      RSP_EMPTY: if (accept) state_d = RSP_FULL;
      RSP_FULL: begin
        if (accept)         state_d = RSP_FULL;
        else if (rsp_ready) state_d = RSP_EMPTY;
      end
      default: state_d = RSP_EMPTY;
    endcase
  end

  // Capture the shifted result and hand priority to the other requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      prio     <= 1'b0;
    end else if (accept) begin
      rsp_id   <= grant1;
      rsp_data <= shift_res;
      rsp_err  <= (mux_op == SHIFT_OP_RSV);
      prio     <= !grant1;
    end
  end

  // Count every completed response handshake, wrapping naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      op_count <= '0;
    else if (rsp_valid && rsp_ready) op_count <= op_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Self-checking bench for shift_unit_arbiter: table-driven single ops, hand
// sequences for arbitration, stalls and reset, and a long random run with a
// scoreboard queue of expected responses.
module tb_shift_unit_arbiter;

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [1:0]  op;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_data, req1_data;
  logic [4:0]  req0_shamt, req1_shamt;
  logic [1:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_data;
  logic [15:0] op_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp0_data, exp1_data;
  logic        exp0_err, exp1_err;

  exp_t        sb[$];
  logic        v_m, prio_m, hold_pending;
  logic [15:0] cnt_m;
  logic        held_id, held_err;
  logic [31:0] held_data;
  int          g0 = 0, g1 = 0;

  vec_t vecs[12];

  shift_unit_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_shamt (req0_shamt),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_shamt (req1_shamt),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  // Reference shifter built from the language operators
  function automatic logic [31:0] refShift(input logic [31:0] d, input logic [4:0] s,
                                           input logic [1:0] op);
    logic [31:0] r;
    case (op)
      2'b00:   r = d << s;
      2'b01:   r = d >> s;
      2'b10:   r = $unsigned($signed(d) >>> s);
      default: r = d;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic driveReq(input logic id, input logic valid, input logic [31:0] d,
                          input logic [4:0] s, input logic [1:0] op,
                          input logic [31:0] ed, input logic ee);
    if (id) begin
      exp1_data = ed; exp1_err = ee;
      req1_data = d; req1_shamt = s; req1_op = op; req1_valid = valid;
    end else begin
      exp0_data = ed; exp0_err = ee;
      req0_data = d; req0_shamt = s; req0_op = op; req0_valid = valid;
    end
  endtask

  // Present one op on its requester and hold it until accepted
  task automatic applyStimulus(input vec_t v);
    bit got = 0;
    driveReq(v.id, 1'b1, v.data, v.shamt, v.op, v.exp_data, v.exp_err);
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (v.id ? req1_ready : req0_ready) got = 1;
    end
    if (!got) checkOutput("accept_timeout", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    if (v.id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic newReq(input logic id);
    logic [31:0] d;
    logic [4:0]  s;
    logic [1:0]  op;
    logic        v;
    d  = $urandom;
    s  = 5'($urandom_range(0, 31));
    op = 2'($urandom_range(0, 3));
    v  = ($urandom_range(0, 9) != 0);
    driveReq(id, v, d, s, op, refShift(d, s, op), (op == 2'b11));
  endtask

  // Scoreboard and protocol model, sampled mid-cycle
  always @(negedge clk) begin
    logic can_m, er0, er1, acc0, acc1;
    exp_t e;
    if (!rst_n) begin
      v_m = 1'b0; prio_m = 1'b0; cnt_m = '0; hold_pending = 1'b0;
      sb.delete();
    end else begin
      can_m = !v_m || rsp_ready;
      er0 = can_m && req0_valid && (!req1_valid || !prio_m);
      er1 = can_m && req1_valid && (!req0_valid || prio_m);
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(v_m));
      checkOutput("req0_ready", 32'(req0_ready), 32'(er0));
      checkOutput("req1_ready", 32'(req1_ready), 32'(er1));
      checkOutput("op_count", 32'(op_count), 32'(cnt_m));
      if (hold_pending) begin
        checkOutput("hold_id", 32'(rsp_id), 32'(held_id));
        checkOutput("hold_data", rsp_data, held_data);
        checkOutput("hold_err", 32'(rsp_err), 32'(held_err));
      end
      if (rsp_valid && rsp_ready) begin
        checkOutput("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
          checkOutput("rsp_data", rsp_data, e.data);
          checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
        end
        cnt_m = cnt_m + 16'd1;
      end
      hold_pending = rsp_valid && !rsp_ready;
      held_id = rsp_id; held_data = rsp_data; held_err = rsp_err;
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      if (acc0) begin
        sb.push_back('{1'b0, exp0_data, exp0_err});
        prio_m = 1'b1;
        g0++;
      end else if (acc1) begin
        sb.push_back('{1'b1, exp1_data, exp1_err});
        prio_m = 1'b0;
        g1++;
      end
      v_m = acc0 || acc1 || (v_m && !rsp_ready);
    end
  end

  // Directed tests followed by the long random run
  initial begin
    int s0, s1, hs, cyc;
    logic a0, a1;

    vecs[0]  = '{1'b0, 32'h8000_0001, 5'd4,  2'b10, 32'hF800_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0003, 5'd31, 2'b00, 32'h8000_0000, 1'b0};
    vecs[2]  = '{1'b1, 32'hFFFF_FFFF, 5'd31, 2'b01, 32'h0000_0001, 1'b0};
    vecs[3]  = '{1'b1, 32'h1234_5678, 5'd7,  2'b11, 32'h1234_5678, 1'b1};
    vecs[4]  = '{1'b0, 32'h1234_5678, 5'd0,  2'b00, 32'h1234_5678, 1'b0};
    vecs[5]  = '{1'b1, 32'h1234_5678, 5'd0,  2'b01, 32'h1234_5678, 1'b0};
    vecs[6]  = '{1'b0, 32'h8765_4321, 5'd0,  2'b10, 32'h8765_4321, 1'b0};
    vecs[7]  = '{1'b1, 32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b0, 32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_F0F0, 5'd4,  2'b00, 32'h000F_0F00, 1'b0};
    vecs[10] = '{1'b0, 32'hF000_0000, 5'd8,  2'b01, 32'h00F0_0000, 1'b0};
    vecs[11] = '{1'b1, 32'h8000_0000, 5'd1,  2'b10, 32'hC000_0000, 1'b0};

    rst_n = 1'b0; rsp_ready = 1'b0;
    driveReq(1'b0, 1'b0, '0, '0, 2'b00, '0, 1'b0);
    driveReq(1'b1, 1'b0, '0, '0, 2'b00, '0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("reset_rsp_data", rsp_data, 32'd0);
    checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("reset_op_count", 32'(op_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; rsp_ready = 1'b1;

    // Single ops from the table, including shamt=0 and reserved op
    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);
    idle(3);

    // Fairness survives idle cycles, then strict alternation under contention
    applyStimulus(vecs[1]);
    idle(2);
    s0 = g0; s1 = g1;
    driveReq(1'b0, 1'b1, 32'h0000_0003, 5'd31, 2'b00, 32'h8000_0000, 1'b0);
    driveReq(1'b1, 1'b1, 32'hFFFF_FFFF, 5'd31, 2'b01, 32'h0000_0001, 1'b0);
    @(negedge clk);
    checkOutput("fair_after_idle", 32'(req1_ready), 32'd1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    checkOutput("alt_grants0", 32'(g0 - s0), 32'd3);
    checkOutput("alt_grants1", 32'(g1 - s1), 32'd3);
    idle(3);

    // Consumer stall with both requesters waiting, then release without bubble
    rsp_ready = 1'b0;
    driveReq(1'b0, 1'b1, 32'h8000_0001, 5'd4, 2'b10, 32'hF800_0000, 1'b0);
    driveReq(1'b1, 1'b1, 32'h0000_0001, 5'd5, 2'b00, 32'h0000_0020, 1'b0);
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      checkOutput("stall_ready", 32'({req0_ready, req1_ready}), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("no_bubble_ready", 32'(req0_ready | req1_ready), 32'd1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    idle(3);

    // Asynchronous reset while a response is pending
    rsp_ready = 1'b0;
    applyStimulus(vecs[0]);
    @(negedge clk);
    checkOutput("full_before_reset", 32'(rsp_valid), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(rsp_valid), 32'd0);
    checkOutput("async_rst_count", 32'(op_count), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1; rsp_ready = 1'b1;
    driveReq(1'b0, 1'b1, 32'h0000_00F0, 5'd4, 2'b01, 32'h0000_000F, 1'b0);
    driveReq(1'b1, 1'b1, 32'h0000_00F0, 5'd4, 2'b00, 32'h0000_0F00, 1'b0);
    @(negedge clk);
    checkOutput("post_rst_grant0", 32'(req0_ready), 32'd1);
    checkOutput("post_rst_grant1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    idle(3);

    // Random ops until the counter wraps past 0xFFFF
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    newReq(1'b0);
    newReq(1'b1);
    hs = 0; cyc = 0;
    while (hs < 65537 && cyc < 90000) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      if (rsp_valid && rsp_ready) hs++;
      @(posedge clk); #1;
      cyc++;
      if (hs == 65537) begin
        rsp_ready = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      end else begin
        if (a0 || !req0_valid) newReq(1'b0);
        if (a1 || !req1_valid) newReq(1'b1);
        rsp_ready = ($urandom_range(0, 7) != 0);
      end
    end
    if (hs != 65537) checkOutput("random_handshakes", 32'(hs), 32'd65537);
    @(negedge clk);
    checkOutput("op_count_wrap", 32'(op_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
